// File: rtl/ps2_key_fifo.sv
// Keyboard event FIFO: captures toggle-strobed PS/2 key events and exposes
// them to a CPU through a data port and a status/control port.
module ps2_key_fifo #(
  parameter int DEPTH   = 16,
  parameter int CNT_SAT = 15
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        key_ready,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [9:0]    mem_q [DEPTH];
  logic          tog_q, arm_q, ovf_q, ovf_d, rdy_q;
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d, waddr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    dout_q, dout_d, status;
  logic [9:0]    head;
  logic [3:0]    cnt_sat;
  logic          push, pop, empty, full, flush, ovf_clr, ovf_set, accept, wen;
  logic          unused_din;

  assign unused_din = ^cpu_din[5:0];

  assign head    = mem_q[rptr_q];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign push    = arm_q && (ps2_key[10] != tog_q);
  assign pop     = cpu_rd && !cpu_addr && !empty;
  assign flush   = cpu_wr && cpu_addr && cpu_din[7];
  assign ovf_clr = cpu_wr && cpu_addr && cpu_din[6];
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign accept  = push && (!full || pop);
  assign ovf_set = push && full && !pop && !flush;
  assign wen     = flush ? push : accept;
  assign waddr   = flush ? '0 : wptr_q;

  always_comb begin
    cnt_sat = (int'(cnt_q) > CNT_SAT) ? 4'(CNT_SAT) : 4'(cnt_q);
    status  = {!empty, ovf_q, !empty & head[9], !empty & head[8], cnt_sat};
  end

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (flush) begin
      // Flush wins over everything queued; a coincident push survives alone.
      rptr_d = '0;
      wptr_d = push ? AW'(1) : '0;
      cnt_d  = push ? CW'(1) : '0;
    end else begin
      wptr_d = wptr_q + AW'(accept);
      rptr_d = rptr_q + AW'(pop);
      cnt_d  = cnt_q + CW'(accept) - CW'(pop);
    end
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    if (cpu_rd) dout_d = cpu_addr ? status : (empty ? 8'h00 : head[7:0]);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q  <= ps2_key[10];
      arm_q  <= 1'b0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      rdy_q  <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      tog_q  <= ps2_key[10];
      arm_q  <= 1'b1;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      rdy_q  <= (cnt_d != '0);
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wen) mem_q[waddr] <= ps2_key[9:0];
  end

  assign cpu_dout  = dout_q;
  assign key_ready = rdy_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for ps2_key_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the keyboard FIFO.
module tb_ps2_key_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_SAT = 15;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        cpu_addr, cpu_rd, cpu_wr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        key_ready, overflow;

  ps2_key_fifo #(.DEPTH(DEPTH), .CNT_SAT(CNT_SAT)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .cpu_addr(cpu_addr),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .key_ready(key_ready), .overflow(overflow));

  always #5 clk_sys = ~clk_sys;

  int errs = 0, nchk = 0;
  logic [9:0] m_q[$];
  logic       m_tog, m_arm, m_ovf;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    int n = m_q.size();
    logic ne = (n != 0);
    int c = (n < CNT_SAT) ? n : CNT_SAT;
    return {ne, m_ovf, ne ? m_q[0][9] : 1'b0, ne ? m_q[0][8] : 1'b0, 4'(c)};
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_tick();
    bit push, pop, flush, clr, was_full;
    logic [7:0] rdval;
    if (reset) begin
      m_q.delete(); m_ovf = 0; m_dout = 8'h00; m_arm = 0; m_tog = ps2_key[10];
      return;
    end
    push     = m_arm && (ps2_key[10] != m_tog);
    pop      = cpu_rd && !cpu_addr && (m_q.size() != 0);
    flush    = cpu_wr && cpu_addr && cpu_din[7];
    clr      = cpu_wr && cpu_addr && cpu_din[6];
    was_full = (m_q.size() == DEPTH);
    if (cpu_rd) begin
      rdval = cpu_addr ? m_status() : ((m_q.size() == 0) ? 8'h00 : m_q[0][7:0]);
      m_dout = rdval;
    end
    if (flush) begin
      m_q.delete();
      if (push) m_q.push_back(ps2_key[9:0]);
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push && (!was_full || pop)) m_q.push_back(ps2_key[9:0]);
    end
    if (push && was_full && !pop && !flush) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_tog = ps2_key[10];
    m_arm = 1;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk_sys); #1;
    chk("dout", 16'(cpu_dout), 16'(m_dout));
    chk("key_ready", 16'(key_ready), 16'(m_q.size() != 0));
    chk("overflow", 16'(overflow), 16'(m_ovf));
  endtask

  task automatic idle();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_din = 0;
  endtask

  task automatic push_ev(input logic [9:0] ev);
    ps2_key = {~ps2_key[10], ev};
    step();
  endtask

  task automatic rd(input logic a);
    cpu_rd = 1; cpu_addr = a; step(); idle();
  endtask

  task automatic wr_stat(input logic [7:0] d);
    cpu_wr = 1; cpu_addr = 1; cpu_din = d; step(); idle();
  endtask

  task automatic do_reset(input logic tog);
    ps2_key = {tog, 10'h0}; reset = 1; step(); step(); reset = 0; step();
  endtask

  initial begin
    idle(); reset = 1; ps2_key = '0;
    do_reset(1'b0);
    chk("rst_dout", 16'(cpu_dout), 16'h00);
    chk("rst_rdy", 16'(key_ready), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);

    // single push then read
    push_ev({1'b1, 1'b0, 8'h1C});
    chk("push_rdy", 16'(key_ready), 16'h1);
    rd(0);
    chk("read_1C", 16'(cpu_dout), 16'h1C);
    chk("rdy_drop", 16'(key_ready), 16'h0);

    // 17 pushes into 16 slots
    for (int i = 1; i <= 17; i++) push_ev({2'b00, 8'(i)});
    chk("ovf_set", 16'(overflow), 16'h1);
    rd(1);
    chk("stat_full", 16'(cpu_dout), 16'hCF);
    for (int i = 1; i <= 16; i++) begin
      rd(0);
      chk("order", 16'(cpu_dout), 16'(i));
    end
    wr_stat(8'h40);
    chk("ovf_clr", 16'(overflow), 16'h0);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_ev({2'b00, 8'(8'h20 + i)});
    cpu_rd = 1; cpu_addr = 0;
    push_ev({2'b00, 8'h55}); idle();
    chk("full_pp_dout", 16'(cpu_dout), 16'h20);
    chk("full_pp_ovf", 16'(overflow), 16'h0);
    for (int i = 1; i < 16; i++) rd(0);
    rd(0);
    chk("new_last", 16'(cpu_dout), 16'h55);
    chk("drained", 16'(key_ready), 16'h0);

    // toggle level held through reset
    do_reset(1'b1);
    step(); step();
    chk("no_push_rst", 16'(key_ready), 16'h0);
    push_ev(10'h0AA);
    rd(1);
    chk("one_entry", 16'(cpu_dout & 8'h0F), 16'h1);

    // overflow set and clear together: set wins
    for (int i = 0; i < 15; i++) push_ev(10'(i));
    cpu_wr = 1; cpu_addr = 1; cpu_din = 8'h40;
    push_ev(10'h3FF); idle();
    chk("set_wins", 16'(overflow), 16'h1);

    // flush + overflow clear with 5 entries left
    for (int i = 0; i < 11; i++) rd(0);
    wr_stat(8'hC0);
    rd(1);
    chk("stat_C0", 16'(cpu_dout), 16'h00);
    chk("rdy_C0", 16'(key_ready), 16'h0);

    // empty read, then extended release
    rd(0);
    chk("empty_rd", 16'(cpu_dout), 16'h00);
    push_ev({1'b0, 1'b1, 8'hE0});
    rd(1);
    chk("stat_91", 16'(cpu_dout), 16'h91);

    // flush + push together leaves one entry
    push_ev(10'h011); push_ev(10'h012);
    cpu_wr = 1; cpu_addr = 1; cpu_din = 8'h80;
    push_ev(10'h3C5); idle();
    rd(1);
    chk("flush_push", 16'(cpu_dout), 16'hB1);
    wr_stat(8'h80);

    // push + data read while empty
    cpu_rd = 1; cpu_addr = 0;
    push_ev(10'h077); idle();
    chk("empty_pp_dout", 16'(cpu_dout), 16'h00);
    chk("empty_pp_rdy", 16'(key_ready), 16'h1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 0) ps2_key = {~ps2_key[10], 10'($urandom)};
      else ps2_key[9:0] = 10'($urandom);
      cpu_rd   = ($urandom_range(0, 2) == 0);
      cpu_addr = 1'($urandom);
      cpu_wr   = ($urandom_range(0, 7) == 0);
      cpu_din  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) cpu_din[7] = 1'b0;
      step();
    end
    reset = 0; idle();
    step();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
